pc_sequencer: RTL

- Consumes the 1-bit branch condition from the flag evaluator, which is driven by the ALU sum/carry and the setflag code.
- Combines that condition with the decoded branch type to own and update the program counter.
- Generates the fetch flush and link-register write for calls.
- Tracks a halted state and a saturating taken-branch counter.
- Sits between decode/flag evaluation and instruction fetch in the single-cycle-issue core.

---
 rtl/kgprisc_pkg.sv | 18 +
 rtl/branch_target_calc.sv | 25 ++
 rtl/pc_sequencer.sv | 122 ++++++++++++
 3 files changed

// File: rtl/kgprisc_pkg.sv
// Shared definitions for the kgprisc core: branch-type codes and sequencer states.
package kgprisc_pkg;

  localparam logic [2:0] BR_NONE = 3'b000;
  localparam logic [2:0] BR_COND = 3'b001;
  localparam logic [2:0] BR_JMP  = 3'b010;
  localparam logic [2:0] BR_JR   = 3'b011;
  localparam logic [2:0] BR_CALL = 3'b100;
  localparam logic [2:0] BR_RET  = 3'b101;
  localparam logic [2:0] BR_HALT = 3'b110;

  typedef enum logic [1:0] {
    ST_RUN   = 2'b00,
    ST_FLUSH = 2'b01,
    ST_HALT  = 2'b10
  } state_t;

endpackage

// File: rtl/branch_target_calc.sv
// Combinational target arithmetic: sequential successor and redirect target.
module branch_target_calc
  import kgprisc_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic [ADDR_W-1:0] pc,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] target_reg,
  input  logic [2:0]        br_type,
  output logic [ADDR_W-1:0] seq,
  output logic [ADDR_W-1:0] next_target
);

  // Register-sourced targets for jump-register/return, PC-relative otherwise; wraps silently.
  always_comb begin
    seq = pc + ADDR_W'(1);
    if (br_type == BR_JR || br_type == BR_RET) begin
      next_target = target_reg;
    end else begin
      next_target = seq + offset;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC, issues fetch flush, link writes,
// halt tracking and a saturating count of redirects.
module pc_sequencer
  import kgprisc_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 32,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              ready,
  input  logic [2:0]        br_type,
  input  logic              flag,
  input  logic [ADDR_W-1:0] offset,
  input  logic [ADDR_W-1:0] target_reg,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic              taken,
  output logic              flush,
  output logic              halted,
  output logic [CNT_W-1:0]  taken_cnt
);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] seq, next_target, pc_nxt;
  logic              accept, redirect, cond_taken, is_call;

  branch_target_calc #(
    .ADDR_W(ADDR_W)
  ) u_target (
    .pc         (pc),
    .offset     (offset),
    .target_reg (target_reg),
    .br_type    (br_type),
    .seq        (seq),
    .next_target(next_target)
  );

  assign ready  = (state == ST_RUN);
  assign flush  = (state == ST_FLUSH);
  assign halted = (state == ST_HALT);
  assign accept = instr_valid && ready;

  // Next-state and next-PC decode; only accepts in RUN change anything.
  always_comb begin
    state_nxt  = state;
    pc_nxt     = pc;
    redirect   = 1'b0;
    cond_taken = 1'b0;
    is_call    = 1'b0;
    unique case (state)
      ST_RUN: begin
        if (accept) begin
          unique case (br_type)
            BR_COND: begin
              if (flag) begin
                pc_nxt     = next_target;
                redirect   = 1'b1;
                cond_taken = 1'b1;
                state_nxt  = ST_FLUSH;
              end else begin
                pc_nxt = seq;
              end
            end
            BR_JMP, BR_JR, BR_RET: begin
              pc_nxt    = next_target;
              redirect  = 1'b1;
              state_nxt = ST_FLUSH;
            end
            BR_CALL: begin
              pc_nxt    = next_target;
              redirect  = 1'b1;
              is_call   = 1'b1;
              state_nxt = ST_FLUSH;
            end
            BR_HALT: begin
              state_nxt = ST_HALT;
            end
            default: begin
              pc_nxt = seq;
            end
          endcase
        end
      end
      ST_FLUSH: state_nxt = ST_RUN;
      ST_HALT:  state_nxt = ST_HALT;
      default:  state_nxt = ST_RUN;
    endcase
  end

  // State, PC, link and pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      pc        <= RESET_PC;
      link_addr <= '0;
      link_we   <= 1'b0;
      taken     <= 1'b0;
    end else begin
      state   <= state_nxt;
      pc      <= pc_nxt;
      link_we <= is_call;
      taken   <= cond_taken;
      if (is_call) begin
        link_addr <= seq;
      end
    end
  end

  // Saturating redirect counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      taken_cnt <= '0;
    end else if (redirect && (taken_cnt != '1)) begin
      taken_cnt <= taken_cnt + CNT_W'(1);
    end
  end

endmodule
